axis_byte_arbiter: RTL

AXIS_BYTE_ARBITER -- requirements
Module: axis_byte_arbiter

---
 rtl/axis_arb_pkg.sv | 19 +
 rtl/rr_priority_select.sv | 35 +++
 rtl/axis_byte_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// Shared constants and types for the AXI-Stream byte arbiter.
// Holds the FSM encoding, parameter defaults and lane slicing helper.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEFAULT   = 4;
    localparam int LANE_BITS_DEFAULT = 8;
    localparam int TIMEOUT_DEFAULT   = 255;

    // Bit offset of lane idx inside a packed NUM_REQ*lane_bits bus.
    function automatic int lane_lsb(input int idx, input int lane_bits);
        return idx * lane_bits;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin search: first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_priority_select #(
    parameter int NUM_REQ  = 4,
    parameter int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_BITS-1:0] rr_ptr,
    output logic [IDX_BITS-1:0] idx,
    output logic                any_req
);

    localparam int SUM_BITS = IDX_BITS + 1;
    localparam logic [SUM_BITS-1:0] WRAP = SUM_BITS'(NUM_REQ);

    logic [SUM_BITS-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = {1'b0, rr_ptr} + SUM_BITS'(off);
            if (cand >= WRAP) begin
                cand = cand - WRAP;
            end
            if (req[cand[IDX_BITS-1:0]]) begin
                idx     = cand[IDX_BITS-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_byte_arbiter.sv
// Round-robin arbiter merging NUM_REQ byte streams into one AXI-Stream toward
// the UART transmitter, holding the grant for a whole message with idle timeout.
module axis_byte_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEFAULT,
    parameter int DATA_BITS = LANE_BITS_DEFAULT,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                         tb_dut_clk,
    input  logic                         tb_dut_rstn,
    input  logic [NUM_REQ*DATA_BITS-1:0] s_axis_tdata,
    input  logic [NUM_REQ-1:0]           s_axis_tvalid,
    input  logic [NUM_REQ-1:0]           s_axis_tlast,
    output logic [NUM_REQ-1:0]           s_axis_tready,
    output logic [DATA_BITS-1:0]         m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [$clog2(NUM_REQ)-1:0]   m_axis_tdest,
    output logic                         timeout_pulse
);

    localparam int IDX_BITS = $clog2(NUM_REQ);
    localparam int CNT_BITS = $clog2(TIMEOUT + 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(NUM_REQ - 1);
    localparam logic [CNT_BITS-1:0] CNT_LIMIT = CNT_BITS'(TIMEOUT);

    arb_state_t state, next_state;

    logic [IDX_BITS-1:0]  grant, next_grant;
    logic [IDX_BITS-1:0]  rr_ptr, next_rr_ptr;
    logic [IDX_BITS-1:0]  sel_idx, grant_succ;
    logic [CNT_BITS-1:0]  idle_cnt, next_idle_cnt;
    logic                 sel_any;
    logic                 lane_valid, lane_last;
    logic [DATA_BITS-1:0] lane_data;
    logic                 beat_xfer, last_xfer, cnt_at_limit, force_release;

    rr_priority_select #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_rr_select (
        .req     (s_axis_tvalid),
        .rr_ptr  (rr_ptr),
        .idx     (sel_idx),
        .any_req (sel_any)
    );

    always_comb begin
        lane_valid   = s_axis_tvalid[grant];
        lane_last    = s_axis_tlast[grant];
        lane_data    = s_axis_tdata[lane_lsb(int'(grant), DATA_BITS) +: DATA_BITS];
        grant_succ   = (grant == LAST_IDX) ? '0 : grant + 1'b1;
        cnt_at_limit = (idle_cnt == CNT_LIMIT);
    end

    // A tlast beat in the timeout cycle wins, so the release is reported as normal.
    always_comb begin
        next_state    = state;
        next_grant    = grant;
        next_rr_ptr   = rr_ptr;
        next_idle_cnt = idle_cnt;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        timeout_pulse = 1'b0;
        beat_xfer     = 1'b0;
        last_xfer     = 1'b0;
        force_release = 1'b0;

        case (state)
            ARB_IDLE: begin
                next_idle_cnt = '0;
                if (sel_any) begin
                    next_state = ARB_GRANT;
                    next_grant = sel_idx;
                end
            end

            ARB_GRANT: begin
                m_axis_tdata         = lane_data;
                m_axis_tvalid        = lane_valid;
                m_axis_tlast         = lane_last;
                s_axis_tready[grant] = m_axis_tready;

                beat_xfer     = lane_valid & m_axis_tready;
                last_xfer     = beat_xfer & lane_last;
                force_release = cnt_at_limit & ~last_xfer;
                timeout_pulse = force_release;

                if (beat_xfer) begin
                    next_idle_cnt = '0;
                end else if (!lane_valid && !cnt_at_limit) begin
                    next_idle_cnt = idle_cnt + 1'b1;
                end

                if (last_xfer || force_release) begin
                    next_state  = ARB_IDLE;
                    next_rr_ptr = grant_succ;
                end
            end

            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge tb_dut_clk or negedge tb_dut_rstn) begin
        if (!tb_dut_rstn) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= next_state;
            grant    <= next_grant;
            rr_ptr   <= next_rr_ptr;
            idle_cnt <= next_idle_cnt;
        end
    end

    assign m_axis_tdest = grant;

endmodule
